// File: rtl/us_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : us_pkg
//  Purpose  : Shared types and constants for the ultrasonic ranger:
//             FSM state encoding, default timing values at 50 MHz, counter
//             widths and the distance saturation value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package us_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Defaults for the 50 MHz board clock.
  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_PERIOD_CYC  = 3_000_000;
  localparam int DEF_TIMEOUT_CYC = 1_250_000;
  localparam int DEF_CYC_PER_CM  = 2900;
  localparam int DEF_DIST_W      = 6;

  // Counter widths for the default timing.
  localparam int PERIOD_W  = $clog2(DEF_PERIOD_CYC);
  localparam int TIMEOUT_W = $clog2(DEF_TIMEOUT_CYC + 1);

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Largest value representable in w bits.
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DIST_MAX = sat_max(DEF_DIST_W);

endpackage
`default_nettype wire

// File: rtl/us_median3.sv
`default_nettype none
// ============================================================================
//  Module   : us_median3
//  Purpose  : Combinational median of three unsigned DIST_W-bit values.
//             Used only when US_MEDIAN_FILTER_EN is defined.
//  Ports    : a, b, c  in  DIST_W  candidate values
//             med      out DIST_W  median of a, b, c
//  Revision : 1.0 - initial release
// ============================================================================
module us_median3
  import us_pkg::*;
#(
  parameter int DIST_W = DEF_DIST_W
) (
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  output logic [DIST_W-1:0] med
);

  logic [DIST_W-1:0] lo;
  logic [DIST_W-1:0] hi;

  // Order a/b, then clamp c into [lo, hi]; the clamped value is the median.
  always_comb begin
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    med = c;
    if (c < lo) begin
      med = lo;
    end else if (c > hi) begin
      med = hi;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
//  Module   : ultrasonic_ranger
//  Purpose  : HC-SR04 style ranging controller. Issues a periodic trigger
//             pulse, times the returned echo and converts the width to whole
//             centimetres (saturating) for the memory-mapped distance bus.
//  Ports    : clock    in  1       system clock, rising edge
//             reset    in  1       synchronous, active-low reset
//             echo     in  1       raw sensor echo (asynchronous)
//             trig     out 1       sensor trigger pulse
//             distance out DIST_W  last valid range in cm
//             valid    out 1       one-cycle strobe on distance update
//             timeout  out 1       last measurement timed out
//  Options  : US_MEDIAN_FILTER_EN - distance is the median of the last three
//             good readings instead of the raw reading.
//  Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger
  import us_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TRIG_CYC    = CLK_HZ / 100_000,           // 10 us
  parameter int PERIOD_CYC  = (CLK_HZ / 1000) * 60,       // 60 ms
  parameter int TIMEOUT_CYC = CLK_HZ / 40,                // 25 ms
  parameter int CYC_PER_CM  = (CLK_HZ / 1_000_000) * 58, // 58 us per cm
  parameter int DIST_W      = DEF_DIST_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout
);

  localparam int PW  = cnt_w(PERIOD_CYC);
  localparam int TW  = cnt_w(TIMEOUT_CYC + 1);
  localparam int TRW = cnt_w(TRIG_CYC);
  localparam int SW  = cnt_w(CYC_PER_CM);
  localparam logic [DIST_W-1:0] CM_MAX = DIST_W'(sat_max(DIST_W));

  // --------------------------------------------------------------------------
  // Echo synchronizer and edge detection (2 flops + previous-value flop)
  // --------------------------------------------------------------------------
  logic echo_s1;
  logic echo_s2;
  logic echo_s3;
  logic echo_rise;
  logic echo_fall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_s3;
  assign echo_fall = ~echo_s2 & echo_s3;

  // --------------------------------------------------------------------------
  // Free-running period counter; the wrap to 0 requests a trigger. It never
  // stalls, so a request arriving outside IDLE is simply lost.
  // --------------------------------------------------------------------------
  logic [PW-1:0] period_cnt;
  logic          trig_req;

  assign trig_req = (period_cnt == PW'(PERIOD_CYC - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (trig_req) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output value selection
  // --------------------------------------------------------------------------
  logic [DIST_W-1:0] cm_cnt;
  logic [DIST_W-1:0] dist_next;

`ifdef US_MEDIAN_FILTER_EN
  logic [DIST_W-1:0] hist0;  // most recent good reading
  logic [DIST_W-1:0] hist1;  // reading before that

  us_median3 #(
    .DIST_W (DIST_W)
  ) u_median (
    .a   (cm_cnt),
    .b   (hist0),
    .c   (hist1),
    .med (dist_next)
  );
`else
  assign dist_next = cm_cnt;
`endif

  // --------------------------------------------------------------------------
  // Measurement FSM
  // --------------------------------------------------------------------------
  state_t         state;
  logic [TRW-1:0] trig_cnt;
  logic [TW-1:0]  width_cnt;    // WAIT_RISE wait time, then echo width
  logic [SW-1:0]  sub_cnt;      // echo cycles within the current centimetre
  logic           outcome_good;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      trig         <= 1'b0;
      distance     <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
      trig_cnt     <= '0;
      width_cnt    <= '0;
      sub_cnt      <= '0;
      cm_cnt       <= '0;
      outcome_good <= 1'b0;
`ifdef US_MEDIAN_FILTER_EN
      hist0        <= '0;
      hist1        <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_req) begin
            state    <= TRIG;
            trig     <= 1'b1;
            trig_cnt <= '0;
          end
        end

        TRIG: begin
          if (trig_cnt == TRW'(TRIG_CYC - 1)) begin
            state     <= WAIT_RISE;
            trig      <= 1'b0;
            width_cnt <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end

        // Only a fresh rise counts: an echo already high on entry shows no
        // rise until it has dropped and come back.
        WAIT_RISE: begin
          if (echo_rise) begin
            state     <= MEASURE;
            width_cnt <= '0;
            sub_cnt   <= '0;
            cm_cnt    <= '0;
          end else if (width_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state        <= DONE;
            outcome_good <= 1'b0;
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end

        // The rise cycle itself is part of the pulse, so every MEASURE
        // cycle, including the one that sees the fall, adds one echo cycle.
        MEASURE: begin
          width_cnt <= width_cnt + 1'b1;
          if (sub_cnt == SW'(CYC_PER_CM - 1)) begin
            sub_cnt <= '0;
            if (cm_cnt != CM_MAX) begin
              cm_cnt <= cm_cnt + 1'b1;
            end
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end

          if (echo_fall) begin
            state        <= DONE;
            outcome_good <= 1'b1;
          end else if (width_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state        <= DONE;
            outcome_good <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          if (outcome_good) begin
            distance <= dist_next;
            valid    <= 1'b1;
            timeout  <= 1'b0;
`ifdef US_MEDIAN_FILTER_EN
            hist1    <= hist0;
            hist0    <= cm_cnt;
`endif
          end else begin
            timeout <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          trig  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
